// File: rtl/udp_seq_table.sv
// Programmable sequential primitive: run-time loaded truth table driving a registered output.
// Optional UDP_SEQ_EDGE_EN adds an input-change bit to the table address.
module udp_seq_table #(
    parameter int   N_IN     = 2,
    parameter logic INIT_OUT = 1'b0,
`ifdef UDP_SEQ_EDGE_EN
    localparam int  AW       = N_IN + 1
`else
    localparam int  AW       = N_IN
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [AW-1:0]   cfg_addr,
    input  logic [1:0]      cfg_val,
    input  logic            cfg_commit,
    input  logic            cfg_unlock,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_data,
    output logic            out_valid,
    output logic            out_q,
    output logic            mode_run
);

    localparam int DEPTH = 1 << AW;

    localparam logic [1:0] ST_CFG   = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [1:0] CODE_ZERO = 2'b00;
    localparam logic [1:0] CODE_ONE  = 2'b01;
    localparam logic [1:0] CODE_HOLD = 2'b10;

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // ready depends only on state, never on valid.
    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [1:0]      tbl [DEPTH];
    logic            s1_valid;
    logic [1:0]      s1_code;
    logic            in_acc;
    logic            cfg_acc;
    logic [AW-1:0]   rd_addr;

    assign cfg_ready = (state == ST_CFG);
    assign in_ready  = (state == ST_RUN);
    assign mode_run  = (state == ST_RUN);
    assign in_acc    = in_valid & in_ready;
    assign cfg_acc   = cfg_valid & cfg_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CFG:   if (cfg_commit) state_nxt = ST_RUN;
            ST_RUN:   if (cfg_unlock) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!s1_valid)  state_nxt = ST_CFG;
            default:                  state_nxt = ST_CFG;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_CFG;
        else     state <= state_nxt;
    end

`ifdef UDP_SEQ_EDGE_EN
    // History forgets the previous RUN session so a fresh session starts from all-zero inputs.
    logic [N_IN-1:0] last_in;

    assign rd_addr = {(in_data != last_in), in_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         last_in <= '0;
        else if (in_acc)                                 last_in <= in_data;
        else if (state == ST_DRAIN && state_nxt == ST_CFG) last_in <= '0;
    end
`else
    assign rd_addr = in_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= CODE_HOLD;
        end else if (cfg_acc) begin
            tbl[cfg_addr] <= cfg_val;
        end
    end

    // Stage 2 works on out_q itself, so chained toggles always see the latest value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_code   <= CODE_HOLD;
            out_valid <= 1'b0;
            out_q     <= INIT_OUT;
        end else begin
            s1_valid  <= in_acc;
            if (in_acc) s1_code <= tbl[rd_addr];
            out_valid <= s1_valid;
            if (s1_valid) begin
                case (s1_code)
                    CODE_ZERO: out_q <= 1'b0;
                    CODE_ONE:  out_q <= 1'b1;
                    CODE_HOLD: out_q <= out_q;
                    default:   out_q <= ~out_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_udp_seq_table.sv
// Bench for udp_seq_table: directed scenarios then random traffic against a queue-based model.
// Edge-address scenario runs only when UDP_SEQ_EDGE_EN is defined.
module tb_udp_seq_table;

    localparam int   N_IN     = 2;
    localparam logic INIT_OUT = 1'b1;
`ifdef UDP_SEQ_EDGE_EN
    localparam int   AW       = N_IN + 1;
`else
    localparam int   AW       = N_IN;
`endif
    localparam int   DEPTH    = 1 << AW;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [AW-1:0]   cfg_addr;
    logic [1:0]      cfg_val;
    logic            cfg_commit;
    logic            cfg_unlock;
    logic            in_valid;
    logic            in_ready;
    logic [N_IN-1:0] in_data;
    logic            out_valid;
    logic            out_q;
    logic            mode_run;

    udp_seq_table #(.N_IN(N_IN), .INIT_OUT(INIT_OUT)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_val(cfg_val),
        .cfg_commit(cfg_commit), .cfg_unlock(cfg_unlock),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_q(out_q), .mode_run(mode_run)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: mode, table contents, and results queued with the call index they appear at
    typedef enum int {M_CFG, M_RUN, M_DRAIN} mmode_t;
    mmode_t          m_mode;
    logic [1:0]      m_tab [DEPTH];
    logic            m_chain;
    logic            m_out;
    logic [N_IN-1:0] m_last;
    logic [0:0]      exp_q[$];
    int              due_q[$];
    int              n_call = 0;
    int              n_vec  = 0;
    int              n_err  = 0;

    function automatic logic apply(input logic [1:0] code, input logic cur);
        case (code)
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            2'b10:   return cur;
            default: return ~cur;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_CFG;
        for (int i = 0; i < DEPTH; i++) m_tab[i] = 2'b10;
        m_chain = INIT_OUT;
        m_out   = INIT_OUT;
        m_last  = '0;
        exp_q.delete();
        due_q.delete();
    endtask

    task automatic check_status(input string ph);
        check({ph, " cfg_ready"}, cfg_ready, m_mode == M_CFG);
        check({ph, " in_ready"},  in_ready,  m_mode == M_RUN);
        check({ph, " mode_run"},  mode_run,  m_mode == M_RUN);
    endtask

    // driver: apply one cycle of inputs, advance the model, check after the edge
    task automatic cycle(input logic cv, input logic [AW-1:0] ca, input logic [1:0] cval,
                         input logic cm, input logic ul, input logic iv, input logic [N_IN-1:0] id);
        logic [AW-1:0] a;
        logic          pend_now;
        cfg_valid = cv; cfg_addr = ca; cfg_val = cval;
        cfg_commit = cm; cfg_unlock = ul; in_valid = iv; in_data = id;
        pend_now = (due_q.size() > 0) && (due_q[0] == n_call);
        case (m_mode)
            M_CFG: begin
                if (cv) m_tab[ca] = cval;
                if (cm) m_mode = M_RUN;
            end
            M_RUN: begin
                if (iv) begin
`ifdef UDP_SEQ_EDGE_EN
                    a = {(id != m_last), id};
                    m_last = id;
`else
                    a = id;
`endif
                    m_chain = apply(m_tab[a], m_chain);
                    exp_q.push_back(m_chain);
                    due_q.push_back(n_call + 1);
                end
                if (ul) m_mode = M_DRAIN;
            end
            default: begin
                if (!pend_now) begin
                    m_mode = M_CFG;
                    m_last = '0;
                end
            end
        endcase
        @(posedge clk);
        #1;
        if (pend_now) begin
            m_out = exp_q.pop_front();
            void'(due_q.pop_front());
        end
        check("out_valid", out_valid, pend_now);
        check("out_q", out_q, m_out);
        check_status("cyc");
        n_call++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b0, '0);
    endtask
    task automatic wr(input logic [AW-1:0] a, input logic [1:0] v);
        cycle(1'b1, a, v, 1'b0, 1'b0, 1'b0, '0);
    endtask
    task automatic commit();
        cycle(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0, '0);
    endtask
    task automatic unlock();
        cycle(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b0, '0);
    endtask
    task automatic feed(input logic [N_IN-1:0] d);
        cycle(1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cfg_valid = 1'b0; cfg_addr = '0; cfg_val = 2'b00;
        cfg_commit = 1'b0; cfg_unlock = 1'b0; in_valid = 1'b0; in_data = '0;
        #1;
        model_reset();
        check("rst out_valid", out_valid, 1'b0);
        check("rst out_q", out_q, INIT_OUT);
        check_status("rst");
        @(posedge clk);
        #1;
        check("rst edge out_valid", out_valid, 1'b0);
        check("rst edge out_q", out_q, INIT_OUT);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // T1: reset state, unprogrammed entry holds INIT_OUT
        do_reset();
        commit();
        feed(2'd0);
        idle(2);
        unlock();
        idle(2);

        // T2: inverter on entries 0/1, back-to-back inputs
        wr(0, 2'b01);
        wr(1, 2'b00);
        commit();
        feed(2'd0);
        feed(2'd1);
        feed(2'd0);
        idle(2);
        unlock();
        idle(2);

        // T3: toggle chain then hold
        wr(3, 2'b11);
        wr(0, 2'b10);
        wr(2, 2'b00);
        commit();
        feed(2'd2);
        feed(2'd3);
        feed(2'd3);
        feed(2'd3);
        feed(2'd0);
        idle(2);

        // T4: unlock together with an accepted input, then a refused write in DRAIN
        cycle(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b1, 2'd3);
        wr(1, 2'b11);
        idle(2);
        commit();
        feed(2'd1);
        idle(2);

        // T5: reset while stage 1 holds a valid entry
        feed(2'd3);
        do_reset();
        commit();
        feed(2'd3);
        feed(2'd1);
        idle(2);

`ifdef UDP_SEQ_EDGE_EN
        // T6: changed input hits the edge entry, unchanged input hits the level entry
        unlock();
        idle(2);
        wr(0, 2'b00);
        wr(5, 2'b01);
        wr(1, 2'b10);
        commit();
        feed(2'd0);
        feed(2'd1);
        feed(2'd1);
        idle(2);
`endif

        // random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                  N_IN'($urandom_range(0, (1 << N_IN) - 1)));
        end
        idle(4);
        check("drained", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
